// File: rtl/mult_ctrl_pkg.sv
// Shared types and defaults for the multiplier-sharing controller.
//   mult_state_e      : controller FSM states
//   MULT_WIDTH_DEF    : default operand/result width (shared with multiplier top)
//   MULT_LATENCY_DEF  : default multiplier latency in cycles after its reset drops
package mult_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} mult_state_e;

  localparam int MULT_WIDTH_DEF   = 1024;
  localparam int MULT_LATENCY_DEF = 1024;

endpackage

// File: rtl/mult_share_arb.sv
// Combinational request arbiter for the shared multiplier.
// Config macro: MULT_SHARE_RR_EN (defined -> round-robin starting at rr_ptr,
//               undefined -> fixed priority, lowest index wins).
// Ports:
//   req_valid : per-requester request valid
//   rr_ptr    : round-robin search start (only with MULT_SHARE_RR_EN)
//   gnt       : one-hot grant, all zeros when nothing is requesting
module mult_share_arb
  import mult_ctrl_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic [N_REQ-1:0]         req_valid,
`ifdef MULT_SHARE_RR_EN
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
`endif
  output logic [N_REQ-1:0]         gnt
);

  logic found;

`ifdef MULT_SHARE_RR_EN
  int idx;

  // Walk N_REQ slots starting at rr_ptr, wrapping; first valid one wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`else
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req_valid[i]) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one start/done-less sequential multiplier among N_REQ requesters.
// Config macro: MULT_SHARE_RR_EN (round-robin arbitration when defined,
//               fixed lowest-index priority otherwise).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b               : packed operands, slice i belongs to requester i
//   resp_valid/resp_ready     : product handshake
//   resp_id/resp_data         : owner of the product, low WIDTH product bits
//   busy                      : controller not idle
//   mult_rst/mult_a/mult_b    : drive the shared multiplier
//   mult_o                    : multiplier result
module mult_share_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int WIDTH        = MULT_WIDTH_DEF,
  parameter int N_REQ        = 2,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*WIDTH-1:0]   req_a,
  input  logic [N_REQ*WIDTH-1:0]   req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [$clog2(N_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]         resp_data,
  output logic                     busy,
  output logic                     mult_rst,
  output logic [WIDTH-1:0]         mult_a,
  output logic [WIDTH-1:0]         mult_b,
  input  logic [WIDTH-1:0]         mult_o
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MULT_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MULT_LATENCY - 1);

  mult_state_e      state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    gnt_id;
  logic             accept;

`ifdef MULT_SHARE_RR_EN
  logic [IW-1:0] rr_ptr;
`endif

  mult_share_arb #(.N_REQ(N_REQ)) u_arb (
    .req_valid (req_valid),
`ifdef MULT_SHARE_RR_EN
    .rr_ptr    (rr_ptr),
`endif
    .gnt       (gnt)
  );

  // One-hot grant to index.
  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (gnt[i]) gnt_id = IW'(i);
  end

  // gnt only marks a valid requester, so a grant in IDLE is the handshake.
  assign accept     = (state == IDLE) && (|gnt);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  // The multiplier has no start; holding it in reset for one cycle is the start.
  assign mult_rst   = rst || (state == CLEAR);

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        req_ready = gnt;
        if (|gnt) state_nxt = CLEAR;
      end
      CLEAR: state_nxt = RUN;
      RUN:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:  if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      resp_id   <= '0;
      resp_data <= '0;
      mult_a    <= '0;
      mult_b    <= '0;
`ifdef MULT_SHARE_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          mult_a  <= req_a[int'(gnt_id)*WIDTH +: WIDTH];
          mult_b  <= req_b[int'(gnt_id)*WIDTH +: WIDTH];
          resp_id <= gnt_id;
`ifdef MULT_SHARE_RR_EN
          rr_ptr  <= (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + IW'(1);
`endif
        end
        CLEAR: cnt <= '0;
        RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) resp_data <= mult_o;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural stand-in for the
// shared multiplier: it reports the true product only once MULT_LATENCY
// cycles have elapsed since its reset dropped, and the bit-inverse before that.
module tb_mult_share_ctrl;

  localparam int W = 1024;
  localparam int L = 1024;
  localparam int N = 2;

  logic           clk, rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic           resp_valid, resp_ready;
  logic [0:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           busy, mult_rst;
  logic [W-1:0]   mult_a, mult_b, mult_o, prod;

  int checks   = 0;
  int failures = 0;
  int mcnt;

  mult_share_ctrl #(.WIDTH(W), .N_REQ(N), .MULT_LATENCY(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .mult_rst   (mult_rst),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .mult_o     (mult_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stand-in.
  assign prod   = mult_a * mult_b;
  assign mult_o = (mcnt >= L - 1) ? prod : ~prod;
  always @(posedge clk) begin
    if (mult_rst)    mcnt <= 0;
    else if (mcnt < L) mcnt <= mcnt + 1;
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed(low128)=%0h expected(low128)=%0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 3 * L) begin
      tick();
      n++;
    end
    chk("resp_timeout", W'(resp_valid), W'(1));
  endtask

  // One request from requester id; optionally scramble its operands every
  // cycle after acceptance. Expected product supplied by the caller.
  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input bit toggle);
    int  n;
    bit  stable;
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    req_valid = oh;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    #1;
    chk("grant", W'(req_ready), W'(oh));
    tick();
    req_valid = '0;
    chk("clear_rst", W'(mult_rst), W'(1));
    chk("busy", W'(busy), W'(1));
    chk("lat_a", mult_a, a);
    chk("lat_b", mult_b, b);
    n = 1;
    stable = 1'b1;
    while (!resp_valid && n < 3 * L) begin
      if (toggle) begin
        req_a = ~req_a;
        req_b = ~req_b;
      end
      tick();
      n++;
      if (n == 2) chk("run_rst", W'(mult_rst), W'(0));
      if (mult_a !== a || mult_b !== b) stable = 1'b0;
    end
    chk("latency", W'(n), W'(L + 2));
    chk("stable", W'(stable), W'(1));
    chk("data", resp_data, exp);
    chk("id", W'(resp_id), W'(id));
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("idle", W'(busy), W'(0));
  endtask

  initial begin
    int n;
    logic [N-1:0] eg;
    logic [W-1:0] big, allones;
    big = '0;
    big[W-1] = 1'b1;
    allones = {1'b0, {(W-1){1'b1}}};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    tick(); tick();
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_rvalid", W'(resp_valid), W'(0));
    chk("rst_id", W'(resp_id), W'(0));
    chk("rst_data", resp_data, W'(0));
    chk("rst_a", mult_a, W'(0));
    chk("rst_b", mult_b, W'(0));
    chk("rst_ready", W'(req_ready), W'(0));
    chk("rst_mrst", W'(mult_rst), W'(1));
    rst = 1'b0;
    tick();
    chk("mrst_off", W'(mult_rst), W'(0));

    // Single op from requester 0.
    do_op(0, W'(3), W'(5), W'(15), 1'b0);

    // Backpressure: requester 1 served, then held in DONE with req1 still valid.
    req_valid = 2'b10;
    req_a[W +: W] = W'(7);
    req_b[W +: W] = W'(9);
    #1;
    chk("bp_grant", W'(req_ready), W'(2'b10));
    tick();
    wait_resp(n);
    repeat (10) begin
      chk("bp_data", resp_data, W'(63));
      chk("bp_id", W'(resp_id), W'(1));
      chk("bp_busy", W'(busy), W'(1));
      chk("bp_ready", W'(req_ready), W'(0));
      chk("bp_valid", W'(resp_valid), W'(1));
      tick();
    end
    resp_ready = 1'b1;
    #1;
    chk("done_nogrant", W'(req_ready), W'(0));
    tick();
    resp_ready = 1'b0;
    chk("bp_idle", W'(busy), W'(0));

    // Contention: both requesters valid continuously.
    req_a = {W'(17), W'(11)};
    req_b = {W'(19), W'(13)};
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef MULT_SHARE_RR_EN
      eg = (k % 2 == 1) ? 2'b10 : 2'b01;
`else
      eg = 2'b01;
`endif
      #1;
      chk("cont_grant", W'(req_ready), W'(eg));
      tick();
      wait_resp(n);
      chk("cont_data", resp_data, eg[1] ? W'(323) : W'(143));
      chk("cont_id", W'(resp_id), W'(eg[1]));
      resp_ready = 1'b1;
      #1;
      chk("cont_nogrant", W'(req_ready), W'(0));
      tick();
      resp_ready = 1'b0;
    end
    req_valid = '0;

    // Overflow truncation, second op also scrambles operands after accept.
    do_op(0, big, W'(2), W'(0), 1'b0);
    do_op(0, allones, W'(1), allones, 1'b1);

    // Reset in the middle of RUN.
    req_valid = 2'b01;
    req_a[0 +: W] = W'(5);
    req_b[0 +: W] = W'(5);
    tick();
    req_valid = '0;
    tick();
    repeat (500) tick();
    chk("mid_busy", W'(busy), W'(1));
    rst = 1'b1;
    tick();
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_rvalid", W'(resp_valid), W'(0));
    chk("abort_mrst", W'(mult_rst), W'(1));
    chk("abort_a", mult_a, W'(0));
    chk("abort_data", resp_data, W'(0));
    rst = 1'b0;
    tick();
    chk("abort_rvalid2", W'(resp_valid), W'(0));
    do_op(1, W'(21), W'(2), W'(42), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
